// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared types for the memory-engine DMA arbiter.
`ifndef BP_ME_DMA_PKT_S_SVH
`define BP_ME_DMA_PKT_S_SVH
`define DECLARE_BP_ME_DMA_PKT_S(addr_width_mp) \
  typedef struct packed { logic write_not_read; logic [addr_width_mp-1:0] addr; } bp_me_dma_pkt_s
`endif

package bp_me_pkg;
  typedef enum logic {e_idle, e_wr_data} bp_me_dma_arb_state_e;
endpackage

// File: rtl/bp_me_dma_rd_tag_fifo.sv
// bp_me_dma_rd_tag_fifo: in-order queue of channel IDs for outstanding reads.
module bp_me_dma_rd_tag_fifo #(
  parameter int width_p = 2,
  parameter int els_p = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [width_p-1:0] push_data,
  input  logic               pop,
  output logic [width_p-1:0] head,
  output logic               full,
  output logic               empty
);
  localparam int pw = els_p > 1 ? $clog2(els_p) : 1;
  localparam int cw = $clog2(els_p + 1);
  logic [els_p-1:0][width_p-1:0] mem;
  logic [pw-1:0] wr_ptr, rd_ptr;
  logic [cw-1:0] count;
  logic do_push, do_pop;
  assign full = count == cw'(els_p);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rd_ptr];
  function automatic logic [pw-1:0] inc(input logic [pw-1:0] p);
    return p == pw'(els_p - 1) ? '0 : p + pw'(1);
  endfunction
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + cw'(do_push) - cw'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/bp_me_dma_arbiter.sv
// bp_me_dma_arbiter: round-robin share of one DRAM DMA port among L2 cache DMA channels;
// writes stream from the granted channel, read returns are steered by a tag FIFO.
module bp_me_dma_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_dma_p = 4,
  parameter int daddr_width_p = 28,
  parameter int fill_width_p = 64,
  parameter int block_size_in_fill_p = 8,
  parameter int max_rd_outstanding_p = 4,
  localparam int pkt_width_lp = daddr_width_p + 1
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,
  input  logic [num_dma_p-1:0][pkt_width_lp-1:0]     dma_pkt_i,
  input  logic [num_dma_p-1:0]                       dma_pkt_v_i,
  output logic [num_dma_p-1:0]                       dma_pkt_yumi_o,
  output logic [num_dma_p-1:0][fill_width_p-1:0]     dma_data_o,
  output logic [num_dma_p-1:0]                       dma_data_v_o,
  input  logic [num_dma_p-1:0]                       dma_data_ready_and_i,
  input  logic [num_dma_p-1:0][fill_width_p-1:0]     dma_data_i,
  input  logic [num_dma_p-1:0]                       dma_data_v_i,
  output logic [num_dma_p-1:0]                       dma_data_yumi_o,
  output logic [pkt_width_lp-1:0]                    mem_pkt_o,
  output logic                                       mem_pkt_v_o,
  input  logic                                       mem_pkt_yumi_i,
  input  logic [fill_width_p-1:0]                    mem_data_i,
  input  logic                                       mem_data_v_i,
  output logic                                       mem_data_ready_and_o,
  output logic [fill_width_p-1:0]                    mem_data_o,
  output logic                                       mem_data_v_o,
  input  logic                                       mem_data_yumi_i
);
  localparam int id_w = $clog2(num_dma_p);
  localparam int cnt_w = block_size_in_fill_p > 1 ? $clog2(block_size_in_fill_p) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(block_size_in_fill_p - 1);
  localparam logic [num_dma_p-1:0] one = {{(num_dma_p-1){1'b0}}, 1'b1};
  bp_me_dma_arb_state_e state;
  logic [id_w-1:0] rr_ptr, wr_id, grant, head;
  logic [cnt_w-1:0] wr_cnt, rd_cnt;
  logic [num_dma_p-1:0] eligible;
  logic full, empty, pkt_hs, is_write, wr_beat, rd_beat, rd_pop;
  function automatic logic [id_w-1:0] rr_pick(input logic [num_dma_p-1:0] req, input logic [id_w-1:0] ptr);
    logic [id_w-1:0] pick;
    logic found;
    int k;
    pick = ptr;
    found = 1'b0;
    for (int i = 0; i < num_dma_p; i++) begin
      k = (int'(ptr) + i) % num_dma_p;
      if (!found && req[k]) begin
        pick = id_w'(k);
        found = 1'b1;
      end
    end
    return pick;
  endfunction
  // reset_n_i gating keeps every command valid/yumi low while reset is held
  always_comb begin
    eligible = '0;
    for (int c = 0; c < num_dma_p; c++)
      eligible[c] = reset_n_i & (state == e_idle) & dma_pkt_v_i[c] & (dma_pkt_i[c][daddr_width_p] | ~full);
  end
  assign grant = rr_pick(eligible, rr_ptr);
  assign is_write = dma_pkt_i[grant][daddr_width_p];
  assign mem_pkt_o = dma_pkt_i[grant];
  assign mem_pkt_v_o = |eligible;
  assign pkt_hs = mem_pkt_v_o & mem_pkt_yumi_i;
  assign dma_pkt_yumi_o = pkt_hs ? one << grant : '0;
  assign mem_data_o = dma_data_i[wr_id];
  assign mem_data_v_o = (state == e_wr_data) & dma_data_v_i[wr_id];
  assign wr_beat = mem_data_v_o & mem_data_yumi_i;
  assign dma_data_yumi_o = wr_beat ? one << wr_id : '0;
  assign dma_data_o = {num_dma_p{mem_data_i}};
  assign dma_data_v_o = (mem_data_v_i & ~empty) ? one << head : '0;
  assign mem_data_ready_and_o = dma_data_ready_and_i[head] & ~empty;
  assign rd_beat = mem_data_v_i & mem_data_ready_and_o;
  assign rd_pop = rd_beat & (rd_cnt == last_beat);
  bp_me_dma_rd_tag_fifo #(
    .width_p(id_w),
    .els_p  (max_rd_outstanding_p)
  ) tag_fifo (
    .clk      (clk_i),
    .reset_n  (reset_n_i),
    .push     (pkt_hs & ~is_write),
    .push_data(grant),
    .pop      (rd_pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= e_idle;
      rr_ptr <= '0;
      wr_id <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (pkt_hs) rr_ptr <= grant == id_w'(num_dma_p - 1) ? '0 : grant + id_w'(1);
      if (pkt_hs & is_write) begin
        state <= e_wr_data;
        wr_id <= grant;
        wr_cnt <= '0;
      end
      if (wr_beat) begin
        wr_cnt <= wr_cnt + cnt_w'(1);
        if (wr_cnt == last_beat) state <= e_idle;
      end
      if (rd_beat) rd_cnt <= rd_pop ? '0 : rd_cnt + cnt_w'(1);
    end
  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(mem_data_v_i && empty));
endmodule

// File: tb/tb_bp_me_dma_arbiter.sv
// tb_bp_me_dma_arbiter: scoreboard bench for the DMA arbiter; expected grants, write beats
// and read returns are queued as stimulus is driven and matched when handshakes occur.
module tb_bp_me_dma_arbiter;
  localparam int n = 4, aw = 28, fw = 64, bs = 8, pw = aw + 1;
  typedef struct {int ch; logic [pw-1:0] pkt;} pkt_t;
  typedef struct {int ch; logic [fw-1:0] d;} beat_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [n-1:0][pw-1:0] dma_pkt = '0;
  logic [n-1:0] dma_pkt_v = '0, dma_pkt_yumi;
  logic [n-1:0][fw-1:0] dma_rdata;
  logic [n-1:0] dma_rdata_v;
  logic [n-1:0] dma_ready = '1;
  logic [n-1:0][fw-1:0] dma_wdata = '0;
  logic [n-1:0] dma_wdata_v = '0, dma_wdata_yumi;
  logic [pw-1:0] mem_pkt;
  logic mem_pkt_v;
  logic mem_pkt_yumi = 1'b1;
  logic [fw-1:0] mem_rdata = '0;
  logic mem_rdata_v = 1'b0, mem_rdata_ready;
  logic [fw-1:0] mem_wdata;
  logic mem_wdata_v;
  logic mem_wdata_yumi = 1'b1;
  pkt_t exp_pkt[$];
  beat_t exp_wd[$], exp_rd[$];
  int tag_model[$];
  int errors = 0, checks = 0, seq = 0;
  logic [n-1:0] pkt_taken = '0, wd_taken = '0;
  logic rd_taken = 1'b0;
  always #5 clk = ~clk;

  bp_me_dma_arbiter dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .dma_pkt_i(dma_pkt), .dma_pkt_v_i(dma_pkt_v), .dma_pkt_yumi_o(dma_pkt_yumi),
    .dma_data_o(dma_rdata), .dma_data_v_o(dma_rdata_v), .dma_data_ready_and_i(dma_ready),
    .dma_data_i(dma_wdata), .dma_data_v_i(dma_wdata_v), .dma_data_yumi_o(dma_wdata_yumi),
    .mem_pkt_o(mem_pkt), .mem_pkt_v_o(mem_pkt_v), .mem_pkt_yumi_i(mem_pkt_yumi),
    .mem_data_i(mem_rdata), .mem_data_v_i(mem_rdata_v), .mem_data_ready_and_o(mem_rdata_ready),
    .mem_data_o(mem_wdata), .mem_data_v_o(mem_wdata_v), .mem_data_yumi_i(mem_wdata_yumi)
  );

  function automatic logic [n-1:0] onehot(input int c);
    logic [n-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // one clock: scoreboard matching at the falling edge, consumed requests retired after the rising edge
  task automatic tick();
    pkt_t p;
    beat_t b;
    @(negedge clk);
    pkt_taken = dma_pkt_yumi;
    wd_taken = dma_wdata_yumi;
    rd_taken = mem_rdata_v & mem_rdata_ready;
    if (mem_pkt_v && mem_pkt_yumi) begin
      checks++;
      if (exp_pkt.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got pkt=%h yumi=%b, required no grant", mem_pkt, dma_pkt_yumi);
      end else begin
        p = exp_pkt.pop_front();
        if (mem_pkt !== p.pkt || dma_pkt_yumi !== onehot(p.ch)) begin
          errors++;
          $display("FAIL grant: got pkt=%h yumi=%b, required pkt=%h yumi=%b", mem_pkt, dma_pkt_yumi, p.pkt, onehot(p.ch));
        end
      end
    end
    if (mem_wdata_v && mem_wdata_yumi) begin
      checks++;
      if (exp_wd.size() == 0) begin
        errors++;
        $display("FAIL wr_beat_unexpected: got data=%h yumi=%b, required none", mem_wdata, dma_wdata_yumi);
      end else begin
        b = exp_wd.pop_front();
        if (mem_wdata !== b.d || dma_wdata_yumi !== onehot(b.ch)) begin
          errors++;
          $display("FAIL wr_beat: got data=%h yumi=%b, required data=%h yumi=%b", mem_wdata, dma_wdata_yumi, b.d, onehot(b.ch));
        end
      end
    end
    if (rd_taken) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_beat_unexpected: got v=%b, required none", dma_rdata_v);
      end else begin
        b = exp_rd.pop_front();
        if (dma_rdata_v !== onehot(b.ch) || dma_rdata[b.ch] !== b.d) begin
          errors++;
          $display("FAIL rd_beat: got v=%b data=%h, required v=%b data=%h", dma_rdata_v, dma_rdata[b.ch], onehot(b.ch), b.d);
        end
      end
    end
    @(posedge clk);
    #1;
    dma_pkt_v &= ~pkt_taken;
  endtask

  task automatic issue(input int ch, input logic wnr, input logic [aw-1:0] addr);
    int t;
    dma_pkt[ch] = {wnr, addr};
    dma_pkt_v[ch] = 1'b1;
    exp_pkt.push_back('{ch, {wnr, addr}});
    if (!wnr) tag_model.push_back(ch);
    t = 0;
    do begin tick(); t++; end while (!pkt_taken[ch] && t < 20);
    checks++;
    if (!pkt_taken[ch]) begin errors++; $display("FAIL issue_timeout ch%0d: got no grant, required grant", ch); end
  endtask

  task automatic write_beats(input int ch, input logic [fw-1:0] base, input int nb);
    int t;
    for (int i = 0; i < nb; i++) begin
      dma_wdata_v[ch] = 1'b1;
      dma_wdata[ch] = base + fw'(i);
      exp_wd.push_back('{ch, base + fw'(i)});
      t = 0;
      do begin tick(); t++; end while (!wd_taken[ch] && t < 20);
      checks++;
      if (!wd_taken[ch]) begin errors++; $display("FAIL wr_timeout ch%0d beat %0d: got no yumi, required yumi", ch, i); end
    end
    dma_wdata_v[ch] = 1'b0;
  endtask

  task automatic return_blocks(input int nblk, input int stall_beat);
    int ch, t;
    logic [fw-1:0] d;
    for (int b = 0; b < nblk; b++) begin
      ch = tag_model.pop_front();
      for (int i = 0; i < bs; i++) begin
        d = {32'(ch), 32'(seq)};
        seq++;
        exp_rd.push_back('{ch, d});
        mem_rdata_v = 1'b1;
        mem_rdata = d;
        if (b == 0 && i == stall_beat) begin
          dma_ready[ch] = 1'b0;
          for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (mem_rdata_ready !== 1'b0 || rd_taken) begin
              errors++;
              $display("FAIL backpressure cycle %0d: got ready=%b taken=%b, required 0 0", s, mem_rdata_ready, rd_taken);
            end
          end
          dma_ready[ch] = 1'b1;
        end
        t = 0;
        do begin tick(); t++; end while (!rd_taken && t < 20);
        checks++;
        if (!rd_taken) begin errors++; $display("FAIL rd_timeout ch%0d beat %0d: got no accept, required accept", ch, i); end
      end
    end
    mem_rdata_v = 1'b0;
  endtask

  task automatic test_reset();
    dma_pkt[0] = {1'b0, 28'h40};
    dma_pkt_v = 4'b0001;
    mem_rdata_v = 1'b1;
    #1;
    checks += 4;
    if (mem_pkt_v !== 1'b0 || dma_pkt_yumi !== '0) begin errors++; $display("FAIL reset_pkt: got v=%b yumi=%b, required 0 0", mem_pkt_v, dma_pkt_yumi); end
    if (mem_rdata_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", mem_rdata_ready); end
    if (dma_rdata_v !== '0) begin errors++; $display("FAIL reset_rdata_v: got %b, required 0", dma_rdata_v); end
    if (mem_wdata_v !== 1'b0 || dma_wdata_yumi !== '0) begin errors++; $display("FAIL reset_wdata: got v=%b yumi=%b, required 0 0", mem_wdata_v, dma_wdata_yumi); end
    dma_pkt_v = '0;
    mem_rdata_v = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (mem_rdata_ready !== 1'b0 || mem_pkt_v !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%b pkt_v=%b, required 0 0", mem_rdata_ready, mem_pkt_v); end
  endtask

  task automatic test_round_robin();
    int t;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < n; c++) begin
        dma_pkt[c] = {1'b0, 28'h1000 + 28'(16 * r + c)};
        exp_pkt.push_back('{c, {1'b0, 28'h1000 + 28'(16 * r + c)}});
        tag_model.push_back(c);
      end
      dma_pkt_v = '1;
      t = 0;
      do begin tick(); t++; end while (dma_pkt_v != '0 && t < 10);
      checks++;
      if (dma_pkt_v != '0) begin errors++; $display("FAIL rr_timeout: pending %b, required 0000", dma_pkt_v); end
      dma_pkt[2] = {1'b0, 28'h2000};
      dma_pkt_v[2] = 1'b1;
      #1;
      checks++;
      if (mem_pkt_v !== 1'b0) begin errors++; $display("FAIL rr_full_block: got pkt_v=%b, required 0", mem_pkt_v); end
      dma_pkt_v[2] = 1'b0;
      return_blocks(4, -1);
    end
  endtask

  task automatic test_single_write();
    issue(2, 1'b1, 28'h100);
    write_beats(2, 64'hA0, bs);
    dma_wdata_v[2] = 1'b1;
    dma_wdata[2] = 64'hFF;
    #1;
    checks++;
    if (mem_wdata_v !== 1'b0 || dma_wdata_yumi !== '0) begin errors++; $display("FAIL write_idle_after_block: got v=%b yumi=%b, required 0 0", mem_wdata_v, dma_wdata_yumi); end
    dma_wdata_v[2] = 1'b0;
  endtask

  task automatic test_read_steering();
    issue(3, 1'b0, 28'h300);
    issue(1, 1'b0, 28'h310);
    return_blocks(2, -1);
  endtask

  task automatic test_backpressure();
    issue(2, 1'b0, 28'h320);
    return_blocks(1, 3);
  endtask

  task automatic test_tag_full();
    int t;
    for (int c = 0; c < n; c++) issue(c, 1'b0, 28'h400 + 28'(c));
    dma_pkt[0] = {1'b0, 28'h480};
    dma_pkt[1] = {1'b1, 28'h490};
    exp_pkt.push_back('{1, {1'b1, 28'h490}});
    exp_pkt.push_back('{0, {1'b0, 28'h480}});
    tag_model.push_back(0);
    dma_pkt_v = 4'b0011;
    t = 0;
    do begin tick(); t++; end while (!pkt_taken[1] && t < 10);
    checks++;
    if (!pkt_taken[1]) begin errors++; $display("FAIL full_write_timeout: got no grant, required ch1 grant"); end
    write_beats(1, 64'hB0, bs);
    tick();
    checks++;
    if (mem_pkt_v !== 1'b0 || dma_pkt_v[0] !== 1'b1) begin errors++; $display("FAIL full_read_stall: got pkt_v=%b pending=%b, required 0 1", mem_pkt_v, dma_pkt_v[0]); end
    return_blocks(5, -1);
    checks++;
    if (exp_pkt.size() != 0 || dma_pkt_v != '0) begin errors++; $display("FAIL full_read_late_grant: got %0d pending grants, required 0", exp_pkt.size()); end
  endtask

  task automatic test_reset_mid_write();
    int t;
    issue(1, 1'b0, 28'h500);
    issue(0, 1'b1, 28'h510);
    write_beats(0, 64'hC0, 4);
    dma_wdata_v[0] = 1'b1;
    dma_wdata[0] = 64'hC4;
    #1;
    checks++;
    if (mem_wdata_v !== 1'b1) begin errors++; $display("FAIL mid_write_valid: got %b, required 1", mem_wdata_v); end
    reset_n = 1'b0;
    #1;
    checks += 2;
    if (mem_wdata_v !== 1'b0 || dma_wdata_yumi !== '0) begin errors++; $display("FAIL async_reset_wdata: got v=%b yumi=%b, required 0 0", mem_wdata_v, dma_wdata_yumi); end
    if (mem_rdata_ready !== 1'b0) begin errors++; $display("FAIL async_reset_ready: got %b, required 0", mem_rdata_ready); end
    tag_model.delete();
    dma_wdata_v = '0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (mem_rdata_ready !== 1'b0) begin errors++; $display("FAIL reset_fifo_empty: got ready=%b, required 0", mem_rdata_ready); end
    dma_pkt[0] = {1'b0, 28'h520};
    dma_pkt[3] = {1'b0, 28'h530};
    exp_pkt.push_back('{0, {1'b0, 28'h520}});
    exp_pkt.push_back('{3, {1'b0, 28'h530}});
    tag_model.push_back(0);
    tag_model.push_back(3);
    dma_pkt_v = 4'b1001;
    t = 0;
    do begin tick(); t++; end while (dma_pkt_v != '0 && t < 10);
    checks++;
    if (dma_pkt_v != '0) begin errors++; $display("FAIL post_reset_grant_timeout: pending %b, required 0000", dma_pkt_v); end
    return_blocks(2, -1);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_read_steering();
    test_backpressure();
    test_tag_full();
    test_reset_mid_write();
    tick();
    checks++;
    if (exp_pkt.size() != 0 || exp_wd.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d left, required 0/0/0", exp_pkt.size(), exp_wd.size(), exp_rd.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
